// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Each accepted operation runs IDLE -> EXEC -> RESP and returns result, flags and requester ID.
module alu_arbiter #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [1:0]   req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [1:0]   req1_op,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [1:0]   alu_op,
    input  logic [W-1:0] alu_r,
    input  logic         alu_cf,
    input  logic         alu_sf,
    input  logic         alu_zf,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_r,
    output logic         rsp_cf,
    output logic         rsp_sf,
    output logic         rsp_zf,
    output logic         busy
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e         state_q, state_d;
    logic           ptr_q, ptr_d;
    logic           id_q, id_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d;
    logic [1:0]     op_q, op_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [W-1:0]   rsp_r_q, rsp_r_d;
    logic           rsp_cf_q, rsp_cf_d, rsp_sf_q, rsp_sf_d, rsp_zf_q, rsp_zf_d;
    logic           grant;
    logic           accept;

    // Pointer only matters when both requesters contend.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ptr_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // Gated by rst_n so no handshake is advertised while reset is held.
    assign req0_ready = rst_n && (state_q == StIdle) && req0_valid && !grant;
    assign req1_ready = rst_n && (state_q == StIdle) && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        rsp_valid_d = rsp_valid_q;
        rsp_r_d     = rsp_r_q;
        rsp_cf_d    = rsp_cf_q;
        rsp_sf_d    = rsp_sf_q;
        rsp_zf_d    = rsp_zf_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    a_d     = grant ? req1_a  : req0_a;
                    b_d     = grant ? req1_b  : req0_b;
                    op_d    = grant ? req1_op : req0_op;
                    id_d    = grant;
                    state_d = StExec;
                end
            end
            StExec: begin
                rsp_r_d     = alu_r;
                rsp_cf_d    = alu_cf;
                rsp_sf_d    = alu_sf;
                rsp_zf_d    = alu_zf;
                rsp_valid_d = 1'b1;
                state_d     = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    ptr_d       = ~id_q;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ptr_q       <= 1'b0;
            id_q        <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_r_q     <= '0;
            rsp_cf_q    <= 1'b0;
            rsp_sf_q    <= 1'b0;
            rsp_zf_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_r_q     <= rsp_r_d;
            rsp_cf_q    <= rsp_cf_d;
            rsp_sf_q    <= rsp_sf_d;
            rsp_zf_q    <= rsp_zf_d;
        end
    end

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_op    = op_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_r     = rsp_r_q;
    assign rsp_cf    = rsp_cf_q;
    assign rsp_sf    = rsp_sf_q;
    assign rsp_zf    = rsp_zf_q;
    assign busy      = (state_q != StIdle);

endmodule
